// File: rtl/cpu_test_sequencer_pkg.sv
// ============================================================================
// cpu_test_sequencer_pkg : state encoding and width helper for the sequencer
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_test_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HOLD = 3'd1,
      ST_RUN  = 3'd2,
      ST_PASS = 3'd3,
      ST_FAIL = 3'd4
   } state_t;

   // Ceiling log2, clamped to 1 so derived vector widths never collapse to zero.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_test_sequencer_exp_table.sv
// ============================================================================
// cpu_exp_table : append-only expected-value register file, async read
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_exp_table
   import cpu_test_sequencer_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int EXP_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          wr_en_i,
   input  logic [DATA_W-1:0]             wr_data_i,
   input  logic                          clear_i,
   input  logic [clog2(EXP_DEPTH)-1:0]   rd_idx_i,
   output logic [DATA_W-1:0]             rd_data_o,
   output logic [clog2(EXP_DEPTH):0]     count_o,
   output logic                          overflow_o
);

   localparam int FI_W  = clog2(EXP_DEPTH);
   localparam int IDX_W = FI_W + 1;
   localparam logic [IDX_W-1:0] DEPTH_C = IDX_W'(EXP_DEPTH);

   logic [DATA_W-1:0] mem_q [EXP_DEPTH];
   logic [IDX_W-1:0]  count_q;
   logic              overflow_q;
   logic              w_full;
   logic              w_write;

   assign w_full  = (count_q == DEPTH_C);
   assign w_write = wr_en_i && !clear_i && !w_full;

   // Contents are deliberately left unreset; only the count defines validity.
   always_ff @(posedge clk_i) begin
      if (w_write) mem_q[count_q[FI_W-1:0]] <= wr_data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clear_i) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (wr_en_i) begin
         if (w_full) overflow_q <= 1'b1;
         else        count_q    <= count_q + IDX_W'(1);
      end
   end

   assign rd_data_o  = mem_q[rd_idx_i];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/cpu_test_sequencer.sv
// ============================================================================
// cpu_test_sequencer : holds CPU in reset, drives switches, checks cpuOut
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_test_sequencer
   import cpu_test_sequencer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int RESET_HOLD = 2,
   parameter int TIMEOUT    = 330,
   parameter int EXP_DEPTH  = 16
) (
   input  logic                          boardCLK,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DATA_W-1:0]             switchPreset,
   input  logic                          expWrEn,
   input  logic [DATA_W-1:0]             expWrData,
   input  logic                          expClear,
   input  logic [DATA_W-1:0]             cpuOut,
   output logic                          cpuReset,
   output logic [DATA_W-1:0]             switches,
   output logic                          busy,
   output logic                          pass,
   output logic                          fail,
   output logic                          timedOut,
   output logic                          expOverflow,
   output logic [clog2(EXP_DEPTH)-1:0]   failIndex,
   output logic [DATA_W-1:0]             gotValue,
   output logic [clog2(TIMEOUT):0]       cycleCount
);

   localparam int FI_W   = clog2(EXP_DEPTH);
   localparam int IDX_W  = FI_W + 1;
   localparam int CC_W   = clog2(TIMEOUT) + 1;
   localparam int HOLD_W = clog2(RESET_HOLD);
   localparam logic [CC_W-1:0]   CC_LAST   = CC_W'(TIMEOUT - 1);
   localparam logic [CC_W-1:0]   CC_MAX    = '1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD - 1);

   state_t              state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [DATA_W-1:0]   prevOut_q;
   logic                cpuReset_q;
   logic [DATA_W-1:0]   switches_q;
   logic                busy_q;
   logic                pass_q;
   logic                fail_q;
   logic                timedOut_q;
   logic [FI_W-1:0]     failIndex_q;
   logic [DATA_W-1:0]   gotValue_q;
   logic [CC_W-1:0]     cycleCount_q;
   logic [CC_W-1:0]     cycleCount_d;

   logic [IDX_W-1:0]    w_exp_count;
   logic [DATA_W-1:0]   w_exp_data;
   logic                w_tbl_wr;
   logic                w_tbl_clr;
   logic                w_changed;
   logic                w_match;
   logic                w_last;

   assign w_tbl_wr     = expWrEn && (state_q == ST_IDLE);
   assign w_tbl_clr    = expClear && (state_q inside {ST_IDLE, ST_PASS, ST_FAIL});
   assign w_changed    = (cpuOut != prevOut_q);
   assign w_match      = (cpuOut == w_exp_data);
   assign w_last       = (idx_q == (w_exp_count - IDX_W'(1)));
   assign cycleCount_d = (cycleCount_q == CC_MAX) ? cycleCount_q : cycleCount_q + CC_W'(1);

   cpu_exp_table #(
      .DATA_W    (DATA_W),
      .EXP_DEPTH (EXP_DEPTH)
   ) u_table (
      .clk_i      (boardCLK),
      .reset_i    (reset),
      .wr_en_i    (w_tbl_wr),
      .wr_data_i  (expWrData),
      .clear_i    (w_tbl_clr),
      .rd_idx_i   (idx_q[FI_W-1:0]),
      .rd_data_o  (w_exp_data),
      .count_o    (w_exp_count),
      .overflow_o (expOverflow)
   );

   always_ff @(posedge boardCLK or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         prevOut_q    <= '0;
         cpuReset_q   <= 1'b1;
         switches_q   <= '0;
         busy_q       <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         timedOut_q   <= 1'b0;
         failIndex_q  <= '0;
         gotValue_q   <= '0;
         cycleCount_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: begin
               if (start) begin
                  state_q      <= ST_HOLD;
                  switches_q   <= switchPreset;
                  idx_q        <= '0;
                  cycleCount_q <= '0;
                  failIndex_q  <= '0;
                  gotValue_q   <= '0;
                  timedOut_q   <= 1'b0;
                  hold_q       <= HOLD_LOAD;
                  busy_q       <= 1'b1;
                  pass_q       <= 1'b0;
                  fail_q       <= 1'b0;
                  cpuReset_q   <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_q == '0) begin
                  if (w_exp_count == '0) begin
                     state_q <= ST_PASS;
                     pass_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= ST_RUN;
                     cpuReset_q <= 1'b0;
                     prevOut_q  <= cpuOut;
                  end
               end else begin
                  hold_q <= hold_q - HOLD_W'(1);
               end
            end
            ST_RUN: begin
               cycleCount_q <= cycleCount_d;
               // A compare decision on the final cycle outranks the timeout.
               if (w_changed) begin
                  prevOut_q <= cpuOut;
                  if (w_match && w_last) begin
                     state_q    <= ST_PASS;
                     pass_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     cpuReset_q <= 1'b1;
                  end else if (w_match) begin
                     idx_q <= idx_q + IDX_W'(1);
                  end else begin
                     state_q     <= ST_FAIL;
                     fail_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     cpuReset_q  <= 1'b1;
                     failIndex_q <= idx_q[FI_W-1:0];
                     gotValue_q  <= cpuOut;
                  end
               end else if (cycleCount_q == CC_LAST) begin
                  state_q     <= ST_FAIL;
                  fail_q      <= 1'b1;
                  timedOut_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  cpuReset_q  <= 1'b1;
                  failIndex_q <= idx_q[FI_W-1:0];
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               cpuReset_q <= 1'b1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign cpuReset   = cpuReset_q;
   assign switches   = switches_q;
   assign busy       = busy_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign timedOut   = timedOut_q;
   assign failIndex  = failIndex_q;
   assign gotValue   = gotValue_q;
   assign cycleCount = cycleCount_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_test_sequencer.sv
// ============================================================================
// tb_cpu_test_sequencer : directed + randomized bench with outcome model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_test_sequencer;

   localparam int DATA_W     = 8;
   localparam int RESET_HOLD = 2;
   localparam int TIMEOUT    = 330;
   localparam int EXP_DEPTH  = 16;
   localparam int SEQ_N      = TIMEOUT + 8;

   logic              boardCLK = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [DATA_W-1:0] switchPreset = '0;
   logic              expWrEn = 1'b0;
   logic [DATA_W-1:0] expWrData = '0;
   logic              expClear = 1'b0;
   logic [DATA_W-1:0] cpuOut = '0;
   logic              cpuReset;
   logic [DATA_W-1:0] switches;
   logic              busy;
   logic              pass;
   logic              fail;
   logic              timedOut;
   logic              expOverflow;
   logic [3:0]        failIndex;
   logic [DATA_W-1:0] gotValue;
   logic [9:0]        cycleCount;

   always #5 boardCLK = ~boardCLK;

   cpu_test_sequencer #(
      .DATA_W     (DATA_W),
      .RESET_HOLD (RESET_HOLD),
      .TIMEOUT    (TIMEOUT),
      .EXP_DEPTH  (EXP_DEPTH)
   ) dut (
      .boardCLK     (boardCLK),
      .reset        (reset),
      .start        (start),
      .switchPreset (switchPreset),
      .expWrEn      (expWrEn),
      .expWrData    (expWrData),
      .expClear     (expClear),
      .cpuOut       (cpuOut),
      .cpuReset     (cpuReset),
      .switches     (switches),
      .busy         (busy),
      .pass         (pass),
      .fail         (fail),
      .timedOut     (timedOut),
      .expOverflow  (expOverflow),
      .failIndex    (failIndex),
      .gotValue     (gotValue),
      .cycleCount   (cycleCount)
   );

   int          n_chk = 0;
   int          n_ok  = 0;
   logic [7:0]  exp_m[$];
   bit          ovf_m;
   logic [7:0]  seq_a [SEQ_N];
   logic [7:0]  tgt_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_ok++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   task automatic tick();
      @(posedge boardCLK);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_m.delete();
      ovf_m = 1'b0;
   endtask

   task automatic tbl_write(input logic [7:0] v);
      expWrEn = 1'b1;
      expWrData = v;
      tick();
      expWrEn = 1'b0;
      if (exp_m.size() < EXP_DEPTH) exp_m.push_back(v);
      else ovf_m = 1'b1;
   endtask

   task automatic tbl_clear();
      expClear = 1'b1;
      tick();
      expClear = 1'b0;
      exp_m.delete();
      ovf_m = 1'b0;
   endtask

   // CPU output trace: each target appears after a random stall, then holds.
   task automatic gen_seq(input logic [7:0] base, input int max_stall);
      logic [7:0] p;
      int pos;
      p = base;
      pos = 0;
      foreach (tgt_q[i]) begin
         repeat ($urandom_range(0, max_stall)) begin
            seq_a[pos] = p;
            pos++;
         end
         seq_a[pos] = tgt_q[i];
         p = tgt_q[i];
         pos++;
      end
      while (pos < SEQ_N) begin
         seq_a[pos] = p;
         pos++;
      end
   endtask

   // Outcome from the list of value changes seen within the RUN window.
   task automatic model(input logic [7:0] base, output bit m_pass, output bit m_to,
                        output int m_fi, output logic [7:0] m_got, output int m_cyc);
      int         ch_cyc[$];
      logic [7:0] ch_val[$];
      logic [7:0] p;
      int         n;
      p = base;
      for (int k = 0; k < TIMEOUT; k++) begin
         if (seq_a[k] != p) begin
            ch_cyc.push_back(k);
            ch_val.push_back(seq_a[k]);
         end
         p = seq_a[k];
      end
      n = exp_m.size();
      m_pass = 1'b0; m_to = 1'b0; m_fi = 0; m_got = '0; m_cyc = 0;
      if (n == 0) begin
         m_pass = 1'b1;
         return;
      end
      for (int j = 0; j < ch_val.size(); j++) begin
         if (ch_val[j] != exp_m[j]) begin
            m_fi = j; m_got = ch_val[j]; m_cyc = ch_cyc[j] + 1;
            return;
         end
         if (j == n - 1) begin
            m_pass = 1'b1; m_cyc = ch_cyc[j] + 1;
            return;
         end
      end
      m_to = 1'b1;
      m_fi = ch_val.size();
      m_cyc = TIMEOUT;
   endtask

   task automatic run_seq(input logic [7:0] preset, input logic [7:0] base,
                          input int start_k, input string tag);
      bit m_pass, m_to;
      int m_fi, m_cyc, k;
      logic [7:0] m_got;
      model(base, m_pass, m_to, m_fi, m_got, m_cyc);
      switchPreset = preset;
      cpuOut = base;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".sw"}, 32'(switches), 32'(preset));
      chk({tag, ".pass_clr"}, 32'(pass), 0);
      chk({tag, ".fail_clr"}, 32'(fail), 0);
      chk({tag, ".to_clr"}, 32'(timedOut), 0);
      for (int h = 0; h < RESET_HOLD; h++) begin
         chk({tag, ".hold_rst"}, 32'(cpuReset), 1);
         tick();
      end
      chk({tag, ".run_rst"}, 32'(cpuReset), (exp_m.size() == 0) ? 1 : 0);
      k = 0;
      while (!(pass || fail) && k < TIMEOUT + 4) begin
         cpuOut = seq_a[k];
         start = (k == start_k);
         tick();
         k++;
      end
      start = 1'b0;
      chk({tag, ".cycles"}, 32'(k), 32'(m_cyc));
      chk({tag, ".pass"}, 32'(pass), 32'(m_pass));
      chk({tag, ".fail"}, 32'(fail), 32'(!m_pass));
      chk({tag, ".timedOut"}, 32'(timedOut), 32'(m_to));
      chk({tag, ".failIndex"}, 32'(failIndex), 32'(m_fi));
      chk({tag, ".gotValue"}, 32'(gotValue), 32'(m_got));
      chk({tag, ".cycleCount"}, 32'(cycleCount), 32'(m_cyc));
      chk({tag, ".busy_end"}, 32'(busy), 0);
      chk({tag, ".rst_end"}, 32'(cpuReset), 1);
      cpuOut = ~cpuOut;
      tick();
      tick();
      chk({tag, ".frozen"}, 32'(cycleCount), 32'(m_cyc));
      chk({tag, ".sticky"}, 32'({pass, fail}), 32'({m_pass, !m_pass}));
      chk({tag, ".sw_hold"}, 32'(switches), 32'(preset));
   endtask

   initial begin
      int n, mode, sel;
      logic [7:0] base;

      do_reset();
      chk("rst.cpuReset", 32'(cpuReset), 1);
      chk("rst.switches", 32'(switches), 0);
      chk("rst.flags", 32'({busy, pass, fail, timedOut, expOverflow}), 0);
      chk("rst.failIndex", 32'(failIndex), 0);
      chk("rst.gotValue", 32'(gotValue), 0);
      chk("rst.cycleCount", 32'(cycleCount), 0);

      tbl_write(8'h01); tbl_write(8'h03); tbl_write(8'h07);
      tgt_q = '{8'h01, 8'h03, 8'h07};
      gen_seq(8'h00, 3);
      run_seq(8'hC2, 8'h00, -1, "t_pass");
      chk("t_pass.p", 32'(pass), 1);

      tgt_q = '{8'h01, 8'h05};
      gen_seq(8'h00, 3);
      run_seq(8'h5A, 8'h00, -1, "t_mis");
      chk("t_mis.fi", 32'(failIndex), 1);
      chk("t_mis.got", 32'(gotValue), 32'h05);

      tgt_q = '{8'h01};
      gen_seq(8'h00, 3);
      run_seq(8'h33, 8'h00, -1, "t_to");
      chk("t_to.to", 32'({fail, timedOut}), 32'b11);
      chk("t_to.cc", 32'(cycleCount), TIMEOUT);

      tgt_q = '{8'h01, 8'h03, 8'h07};
      gen_seq(8'h00, 4);
      run_seq(8'h99, 8'h00, 2, "t_restart");

      do_reset();
      for (int i = 0; i < 17; i++) tbl_write(8'(i + 1));
      chk("ovf.count", 32'(dut.u_table.count_q), 32'(exp_m.size()));
      chk("ovf.flag", 32'(expOverflow), 32'(ovf_m));
      expWrEn = 1'b1; expWrData = 8'hEE; expClear = 1'b1;
      tick();
      expWrEn = 1'b0; expClear = 1'b0;
      exp_m.delete(); ovf_m = 1'b0;
      chk("clr.count", 32'(dut.u_table.count_q), 0);
      chk("clr.flag", 32'(expOverflow), 32'(ovf_m));
      gen_seq(8'h10, 2);
      run_seq(8'h77, 8'h10, -1, "t_empty");

      do_reset();
      tbl_write(8'h01); tbl_write(8'h03); tbl_write(8'h07);
      cpuOut = 8'h00; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (RESET_HOLD) tick();
      cpuOut = 8'h01;
      tick();
      chk("abort.run", 32'(cpuReset), 0);
      reset = 1'b1;
      #1;
      chk("abort.async_rst", 32'(cpuReset), 1);
      tick();
      chk("abort.idle", 32'({busy, pass, fail}), 0);
      reset = 1'b0;
      exp_m.delete(); ovf_m = 1'b0;
      tgt_q = '{8'h01, 8'h03, 8'h07};
      gen_seq(8'h00, 2);
      run_seq(8'hC2, 8'h00, -1, "t_rerun");

      for (int it = 0; it < 12; it++) begin
         do_reset();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) tbl_write(8'($urandom_range(0, 255)));
         base = 8'($urandom_range(0, 255));
         mode = $urandom_range(0, 3);
         tgt_q = exp_m;
         if (mode == 1) begin
            sel = $urandom_range(0, n - 1);
            tgt_q[sel] = tgt_q[sel] ^ 8'($urandom_range(1, 255));
         end else if (mode == 2) begin
            void'(tgt_q.pop_back());
         end
         if (mode == 3) begin
            for (int k = 0; k < SEQ_N; k++) seq_a[k] = 8'($urandom_range(0, 3));
         end else begin
            gen_seq(base, 6);
         end
         run_seq(8'($urandom_range(0, 255)), base,
                 ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1,
                 $sformatf("rnd%0d", it));
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
